// File: rtl/wb_trace_buffer.sv
// Writeback trace FIFO: captures GPR writes from the pipeline writeback stage
// and presents them first-word-fall-through to a consumer, counting dropped events.
module wb_trace_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNTW  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_en,
  input  logic [31:0]     wb_pc,
  input  logic [4:0]      wb_addr,
  input  logic [31:0]     wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_pc,
  output logic [4:0]      out_addr,
  output logic [31:0]     out_data,
  output logic [CNTW-1:0] count,
  output logic            full,
  output logic [15:0]     ovf_cnt
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0] pc_mem   [DEPTH];
  logic [4:0]  addr_mem [DEPTH];
  logic [31:0] data_mem [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [15:0]     ovf_q, ovf_d;

  logic push_req, push, pop, drop;

  assign out_valid = (count_q != '0);
  assign full      = (count_q == CNTW'(DEPTH));
  assign pop       = out_valid & out_ready;
  // Writes to x0 are architectural no-ops and are never traced.
  assign push_req  = wb_en & (wb_addr != 5'd0);
  assign push      = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !pop)      count_d = count_q + CNTW'(1);
    else if (pop && !push) count_d = count_q - CNTW'(1);
    if (drop && ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is deliberately unreset; slots are only visible once counted.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= wb_pc;
      addr_mem[wr_ptr_q] <= wb_addr;
      data_mem[wr_ptr_q] <= wb_data;
    end
  end

  always_comb begin
    out_pc   = '0;
    out_addr = '0;
    out_data = '0;
    if (out_valid) begin
      out_pc   = pc_mem[rd_ptr_q];
      out_addr = addr_mem[rd_ptr_q];
      out_data = data_mem[rd_ptr_q];
    end
  end

  assign count   = count_q;
  assign ovf_cnt = ovf_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Scenario bench for wb_trace_buffer: expected entries are queued as writes are
// driven and compared against the head whenever the consumer accepts it.
module tb_wb_trace_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wb_en = 1'b0;
  logic [31:0] wb_pc = '0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic [3:0]  count;
  logic        full;
  logic [15:0] ovf_cnt;

  int errors = 0;
  int checks = 0;
  logic [68:0] sb[$];
  logic [68:0] exp_e;

  wb_trace_buffer #(.DEPTH(8), .CNTW(4)) dut (
    .clk(clk), .reset(reset), .wb_en(wb_en), .wb_pc(wb_pc), .wb_addr(wb_addr),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_addr(out_addr), .out_data(out_data), .count(count), .full(full),
    .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic clk_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_write(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_pc = pc; wb_addr = a; wb_data = d;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    wb_en = 1'b0;
    out_ready = 1'b0;
    sb.delete();
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({out_valid, full, count, ovf_cnt} !== 22'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b full=%b count=%0d ovf=%0d, required all 0",
               out_valid, full, count, ovf_cnt);
    end
    checks++;
    if ({out_pc, out_addr, out_data} !== 69'd0) begin
      errors++;
      $display("FAIL reset_out: pc=%h addr=%0d data=%h, required 0", out_pc, out_addr, out_data);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single_write();
    out_ready = 1'b0;
    set_write(32'h3000, 5'd8, 32'h1234);
    sb.push_back({32'h3000, 5'd8, 32'h1234});
    clk_edge();
    wb_en = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || count !== 4'd1) begin
      errors++;
      $display("FAIL single_valid: valid=%b count=%0d, required 1/1", out_valid, count);
    end
    out_ready = 1'b1;
    exp_e = sb.pop_front();
    checks++;
    if ({out_pc, out_addr, out_data} !== exp_e) begin
      errors++;
      $display("FAIL single_data: got %h, required %h", {out_pc, out_addr, out_data}, exp_e);
    end
    clk_edge();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || count !== 4'd0 || {out_pc, out_addr, out_data} !== 69'd0) begin
      errors++;
      $display("FAIL single_empty: valid=%b count=%0d out=%h, required 0/0/0",
               out_valid, count, {out_pc, out_addr, out_data});
    end
  endtask

  task automatic test_zero_filter();
    set_write(32'h3004, 5'd0, 32'hFFFF_FFFF);
    clk_edge();
    wb_en = 1'b0;
    checks++;
    if (count !== 4'd0 || out_valid !== 1'b0 || ovf_cnt !== 16'd0) begin
      errors++;
      $display("FAIL zero_filter: count=%0d valid=%b ovf=%0d, required 0/0/0",
               count, out_valid, ovf_cnt);
    end
  endtask

  task automatic test_fill_overflow();
    out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      set_write(32'h1000 + i, 5'(i), 32'h111 * i);
      if (i <= 8) sb.push_back({32'h1000 + i, 5'(i), 32'h111 * i});
      clk_edge();
    end
    wb_en = 1'b0;
    checks++;
    if (count !== 4'd8 || full !== 1'b1 || ovf_cnt !== 16'd2) begin
      errors++;
      $display("FAIL fill_ovf: count=%0d full=%b ovf=%0d, required 8/1/2", count, full, ovf_cnt);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || {out_pc, out_addr, out_data} !== exp_e) begin
        errors++;
        $display("FAIL fill_drain[%0d]: valid=%b got %h, required %h", i, out_valid,
                 {out_pc, out_addr, out_data}, exp_e);
      end
      clk_edge();
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || full !== 1'b0) begin
      errors++;
      $display("FAIL fill_empty: valid=%b full=%b, required 0/0", out_valid, full);
    end
  endtask

  task automatic test_full_push_pop();
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      set_write(32'h2000 + i, 5'(i), 32'hA000 + i);
      sb.push_back({32'h2000 + i, 5'(i), 32'hA000 + i});
      clk_edge();
    end
    set_write(32'h2FFC, 5'd31, 32'hDEAD_BEEF);
    out_ready = 1'b1;
    exp_e = sb.pop_front();
    sb.push_back({32'h2FFC, 5'd31, 32'hDEAD_BEEF});
    checks++;
    if (full !== 1'b1 || {out_pc, out_addr, out_data} !== exp_e) begin
      errors++;
      $display("FAIL fullpp_head: full=%b got %h, required 1/%h", full,
               {out_pc, out_addr, out_data}, exp_e);
    end
    clk_edge();
    wb_en = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (count !== 4'd8 || full !== 1'b1 || ovf_cnt !== 16'd2) begin
      errors++;
      $display("FAIL fullpp_count: count=%0d full=%b ovf=%0d, required 8/1/2",
               count, full, ovf_cnt);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || {out_pc, out_addr, out_data} !== exp_e) begin
        errors++;
        $display("FAIL fullpp_drain[%0d]: valid=%b got %h, required %h", i, out_valid,
                 {out_pc, out_addr, out_data}, exp_e);
      end
      if (i == 7) begin
        checks++;
        if (out_addr !== 5'd31) begin
          errors++;
          $display("FAIL fullpp_last: addr=%0d, required 31", out_addr);
        end
      end
      clk_edge();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_wrap_stream();
    int popped = 0;
    int max_cnt = 0;
    do_reset();
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 21; i++) begin
      if (i < 20) begin
        set_write(32'h4000 + 4 * i, 5'(1 + (i % 31)), $urandom);
        sb.push_back({wb_pc, wb_addr, wb_data});
      end else begin
        wb_en = 1'b0;
      end
      if (out_valid) begin
        exp_e = sb.pop_front();
        popped++;
        checks++;
        if ({out_pc, out_addr, out_data} !== exp_e) begin
          errors++;
          $display("FAIL wrap_order[%0d]: got %h, required %h", popped,
                   {out_pc, out_addr, out_data}, exp_e);
        end
      end
      clk_edge();
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    out_ready = 1'b0;
    checks++;
    if (popped != 20 || max_cnt > 1 || ovf_cnt !== 16'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_summary: popped=%0d maxcnt=%0d ovf=%0d valid=%b, required 20/<=1/0/0",
               popped, max_cnt, ovf_cnt, out_valid);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      set_write(32'h6000 + i, 5'(i), 32'h6600 + i);
      clk_edge();
    end
    wb_en = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) clk_edge();
    out_ready = 1'b0;
    checks++;
    if (count !== 4'd5 || ovf_cnt !== 16'd2) begin
      errors++;
      $display("FAIL areset_pre: count=%0d ovf=%0d, required 5/2", count, ovf_cnt);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (count !== 4'd0 || ovf_cnt !== 16'd0 || out_valid !== 1'b0 || out_pc !== 32'd0) begin
      errors++;
      $display("FAIL areset_async: count=%0d ovf=%0d valid=%b pc=%h, required 0/0/0/0",
               count, ovf_cnt, out_valid, out_pc);
    end
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    set_write(32'h5000, 5'd7, 32'hABCD);
    sb.push_back({32'h5000, 5'd7, 32'hABCD});
    clk_edge();
    wb_en = 1'b0;
    exp_e = sb.pop_front();
    checks++;
    if (count !== 4'd1 || {out_pc, out_addr, out_data} !== exp_e) begin
      errors++;
      $display("FAIL areset_resume: count=%0d got %h, required 1/%h", count,
               {out_pc, out_addr, out_data}, exp_e);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_zero_filter();
    test_fill_overflow();
    test_full_push_pop();
    test_wrap_stream();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
